// File: rtl/mem_req_arbiter.sv
// N-master to 1-slave memory request arbiter with one transaction in flight,
// fixed-priority or round-robin grant, and a WAIT-state response watchdog.
module mem_req_arbiter #(
    parameter int NUM_MST     = 2,
    parameter int ADDR_WD     = 64,
    parameter int DATA_WD     = 64,
    parameter int WEN_WD      = 8,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_MST-1:0]         m_req_valid,
    output logic [NUM_MST-1:0]         m_req_ready,
    input  logic [NUM_MST*WEN_WD-1:0]  m_req_wen,
    input  logic [NUM_MST*ADDR_WD-1:0] m_req_addr,
    input  logic [NUM_MST*DATA_WD-1:0] m_req_wdata,
    output logic [NUM_MST-1:0]         m_resp_valid,
    output logic                       m_resp_err,
    output logic [DATA_WD-1:0]         m_resp_rdata,
    output logic                       bus_req_valid,
    input  logic                       bus_req_ready,
    output logic [WEN_WD-1:0]          bus_req_wen,
    output logic [ADDR_WD-1:0]         bus_req_addr,
    output logic [DATA_WD-1:0]         bus_req_wdata,
    input  logic                       bus_resp_valid,
    input  logic [DATA_WD-1:0]         bus_resp_rdata
);

    localparam int IDX_WD   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int TMR_WD   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [IDX_WD-1:0] grant_q, grant_d, rr_ptr_q;
    logic              grant_vld;
    logic [TMR_WD-1:0] timer_q;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TMR_WD'(TMO_LAST));

    // Search order starts at rr_ptr in round-robin mode, at 0 otherwise.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        idx       = 0;
        grant_d   = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            idx = (ARB_MODE == 1) ? int'(rr_ptr_q) + k : k;
            if (idx >= NUM_MST) idx = idx - NUM_MST;
            if (!grant_vld && m_req_valid[IDX_WD'(idx)]) begin
                grant_vld = 1'b1;
                grant_d   = IDX_WD'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        m_req_ready   = '0;
        bus_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    m_req_ready[grant_d] = 1'b1;
                    state_d              = ISSUE;
                end
            end
            ISSUE: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus_resp_valid || timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Keep handshakes quiet while reset is held so no grant is lost.
        if (reset) begin
            m_req_ready   = '0;
            bus_req_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            bus_req_wen   <= '0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            m_resp_valid  <= '0;
            m_resp_err    <= 1'b0;
            m_resp_rdata  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            m_resp_valid <= '0;
            m_resp_err   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        grant_q       <= grant_d;
                        bus_req_wen   <= m_req_wen[int'(grant_d) * WEN_WD +: WEN_WD];
                        bus_req_addr  <= m_req_addr[int'(grant_d) * ADDR_WD +: ADDR_WD];
                        bus_req_wdata <= m_req_wdata[int'(grant_d) * DATA_WD +: DATA_WD];
                        if (ARB_MODE == 1)
                            rr_ptr_q <= (grant_d == IDX_WD'(NUM_MST - 1)) ? '0 : grant_d + 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus_req_ready) timer_q <= '0;
                end
                WAIT: begin
                    if (bus_resp_valid) begin
                        m_resp_valid[grant_q] <= 1'b1;
                        m_resp_rdata          <= bus_resp_rdata;
                    end else if (timeout_hit) begin
                        m_resp_valid[grant_q] <= 1'b1;
                        m_resp_err            <= 1'b1;
                        m_resp_rdata          <= '0;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: a 3-master round-robin instance with a
// 4-cycle watchdog and a 2-master fixed-priority instance, checked against a transaction-level model.
module tb_mem_req_arbiter;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // round-robin instance
    logic [2:0]   mv = '0, mrdy, rv;
    logic [23:0]  mwen = '0;
    logic [191:0] maddr = '0, mwdata = '0;
    logic         rerr, bv, brdy = 1'b0, bresp = 1'b0;
    logic [63:0]  rdata, baddr, bwdata, brdata = '0;
    logic [7:0]   bwen;

    // fixed-priority instance
    logic [1:0]   fv = '0, frdy, frv;
    logic [15:0]  fwen = '0;
    logic [127:0] faddr = '0, fwdata = '0;
    logic         ferr, fbv, fbrdy = 1'b0, fbresp = 1'b0;
    logic [63:0]  frdata, fbaddr, fbwdata, fbrdata = '0;
    logic [7:0]   fbwen;

    mem_req_arbiter #(.NUM_MST(3), .ADDR_WD(64), .DATA_WD(64), .WEN_WD(8),
                      .ARB_MODE(1), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(rst),
        .m_req_valid(mv), .m_req_ready(mrdy), .m_req_wen(mwen), .m_req_addr(maddr),
        .m_req_wdata(mwdata), .m_resp_valid(rv), .m_resp_err(rerr), .m_resp_rdata(rdata),
        .bus_req_valid(bv), .bus_req_ready(brdy), .bus_req_wen(bwen), .bus_req_addr(baddr),
        .bus_req_wdata(bwdata), .bus_resp_valid(bresp), .bus_resp_rdata(brdata));

    mem_req_arbiter #(.NUM_MST(2), .ADDR_WD(64), .DATA_WD(64), .WEN_WD(8),
                      .ARB_MODE(0), .TIMEOUT_CYC(0)) dut_fp (
        .clk(clk), .reset(rst),
        .m_req_valid(fv), .m_req_ready(frdy), .m_req_wen(fwen), .m_req_addr(faddr),
        .m_req_wdata(fwdata), .m_resp_valid(frv), .m_resp_err(ferr), .m_resp_rdata(frdata),
        .bus_req_valid(fbv), .bus_req_ready(fbrdy), .bus_req_wen(fbwen), .bus_req_addr(fbaddr),
        .bus_req_wdata(fbwdata), .bus_resp_valid(fbresp), .bus_resp_rdata(fbrdata));

    int n_chk = 0, n_fail = 0;
    int rr_m = 0;
    int last_g = -1;
    logic [2:0]  pend_rv = '0;
    logic        pend_err = 1'b0;
    logic [63:0] pend_rdata = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        mv = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) begin
            mwen[i*8 +: 8]    = 8'($urandom);
            maddr[i*64 +: 64] = {$urandom, $urandom};
            mwdata[i*64 +: 64] = {$urandom, $urandom};
        end
    endtask

    // Round-robin reference: first requester at or after the pointer, wrapping.
    function automatic int model_grant(input logic [2:0] v);
        for (int k = 0; k < 3; k++)
            if (v[(rr_m + k) % 3]) return (rr_m + k) % 3;
        return -1;
    endfunction

    // One full transaction on the round-robin instance. The IDLE cycle also
    // checks the response pulse left pending by the previous transaction.
    task automatic run_txn(input logic [2:0] v, input int stall, input int lat, input logic stray);
        int g;
        logic [2:0]  exp_rdy;
        logic [7:0]  e_wen;
        logic [63:0] e_addr, e_wd, rd;
        scramble();
        mv = v; brdy = 1'b0; bresp = stray; brdata = {$urandom, $urandom};
        #2;
        n_chk++; if (rv !== pend_rv) begin n_fail++; $display("FAIL resp_valid: got %b want %b", rv, pend_rv); end
        n_chk++; if (rerr !== pend_err) begin n_fail++; $display("FAIL resp_err: got %b want %b", rerr, pend_err); end
        if (pend_rv != 0) begin
            n_chk++; if (rdata !== pend_rdata) begin n_fail++; $display("FAIL resp_rdata: got %h want %h", rdata, pend_rdata); end
        end
        g = model_grant(v);
        exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
        n_chk++; if (mrdy !== exp_rdy) begin n_fail++; $display("FAIL grant: got %b want %b (valid %b)", mrdy, exp_rdy, v); end
        n_chk++; if (bv !== 1'b0) begin n_fail++; $display("FAIL idle_bus_valid: got %b want 0", bv); end
        pend_rv = '0; pend_err = 1'b0;
        if (g >= 0) begin
            e_wen = mwen[g*8 +: 8]; e_addr = maddr[g*64 +: 64]; e_wd = mwdata[g*64 +: 64];
        end else begin
            e_wen = '0; e_addr = '0; e_wd = '0;
        end
        step();
        if (g < 0) return;
        last_g = g;
        rr_m = (g + 1) % 3;
        for (int s = 0; s <= stall; s++) begin
            scramble();
            brdy = (s == stall); bresp = 1'($urandom_range(0, 1));
            #2;
            n_chk++; if (bv !== 1'b1) begin n_fail++; $display("FAIL issue_valid: got %b want 1", bv); end
            n_chk++; if (baddr !== e_addr) begin n_fail++; $display("FAIL issue_addr: got %h want %h", baddr, e_addr); end
            n_chk++; if (bwen !== e_wen) begin n_fail++; $display("FAIL issue_wen: got %h want %h", bwen, e_wen); end
            n_chk++; if (bwdata !== e_wd) begin n_fail++; $display("FAIL issue_wdata: got %h want %h", bwdata, e_wd); end
            n_chk++; if (mrdy !== 3'b000) begin n_fail++; $display("FAIL issue_ready: got %b want 000", mrdy); end
            n_chk++; if (rv !== 3'b000) begin n_fail++; $display("FAIL issue_resp: got %b want 000", rv); end
            step();
        end
        brdy = 1'b0;
        for (int w = 0; w < 8; w++) begin
            scramble();
            bresp = (w == lat); rd = {$urandom, $urandom}; brdata = rd;
            #2;
            n_chk++; if (bv !== 1'b0) begin n_fail++; $display("FAIL wait_valid: got %b want 0", bv); end
            n_chk++; if (mrdy !== 3'b000) begin n_fail++; $display("FAIL wait_ready: got %b want 000", mrdy); end
            n_chk++; if (rv !== 3'b000) begin n_fail++; $display("FAIL wait_resp: got %b want 000", rv); end
            step();
            if (w == lat) begin
                pend_rv = 3'(1 << g); pend_err = 1'b0; pend_rdata = rd;
                break;
            end
            if (w == TMO - 1) begin
                pend_rv = 3'(1 << g); pend_err = 1'b1; pend_rdata = '0;
                break;
            end
        end
        bresp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #2;
        n_chk++; if ({mrdy, rv, rerr, bv} !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {mrdy, rv, rerr, bv}); end
        n_chk++; if ({rdata, baddr, bwdata, bwen} !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero want 0"); end
        n_chk++; if ({frdy, frv, ferr, fbv, fbaddr} !== '0) begin n_fail++; $display("FAIL reset_fp: got nonzero want 0"); end
        step();
        rr_m = 0; pend_rv = '0; pend_err = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++) begin
            run_txn(3'b011, 0, 0, 1'b0);
            n_chk++; if (last_g !== k % 2) begin n_fail++; $display("FAIL rr_sequence: got %0d want %0d", last_g, k % 2); end
        end
        run_txn(3'b000, 0, 0, 1'b0);
    endtask

    task automatic test_read_latency();
        run_txn(3'b001, 0, 0, 1'b0);
        run_txn(3'b000, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_txn(3'b100, 5, 1, 1'b0);
        run_txn(3'b000, 0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(3'b010, 0, 7, 1'b0);
        run_txn(3'b000, 0, 0, 1'b1);
        run_txn(3'b000, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        scramble(); mv = 3'b100; brdy = 1'b0; bresp = 1'b0;
        #2;
        n_chk++; if (mrdy !== 3'b100) begin n_fail++; $display("FAIL mid_grant: got %b want 100", mrdy); end
        step();
        mv = '0; brdy = 1'b1;
        #2;
        n_chk++; if (bv !== 1'b1) begin n_fail++; $display("FAIL mid_issue: got %b want 1", bv); end
        step();
        brdy = 1'b0; bresp = 1'b1; brdata = 64'h1234_5678_9abc_def0; rst = 1'b1;
        step();
        rst = 1'b0; bresp = 1'b0;
        #2;
        n_chk++; if ({mrdy, rv, rerr, bv} !== 8'h00) begin n_fail++; $display("FAIL mid_reset_ctrl: got %b want 0", {mrdy, rv, rerr, bv}); end
        n_chk++; if ({rdata, baddr, bwdata, bwen} !== '0) begin n_fail++; $display("FAIL mid_reset_data: got nonzero want 0"); end
        step();
        n_chk++; if (rv !== 3'b000) begin n_fail++; $display("FAIL mid_no_pulse: got %b want 000", rv); end
        rr_m = 0; pend_rv = '0; pend_err = 1'b0;
        run_txn(3'b110, 0, 1, 1'b0);
        n_chk++; if (last_g !== 1) begin n_fail++; $display("FAIL mid_fresh_grant: got %0d want 1", last_g); end
        run_txn(3'b000, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++)
            run_txn(3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 5),
                    1'($urandom_range(0, 1)));
        run_txn(3'b000, 0, 0, 1'b1);
    endtask

    task automatic test_fixed_priority();
        logic [1:0]  fpend, exp;
        logic [63:0] fpend_rd, fa, rd;
        fbrdy = 1'b1; fbresp = 1'b1;
        faddr = {64'hAAAA_0001_0000_1000, 64'h0000_0000_8000_0000};
        fv = 2'b11;
        #2;
        n_chk++; if (frdy !== 2'b01) begin n_fail++; $display("FAIL fp_both: got %b want 01", frdy); end
        step();
        fv = 2'b10;
        #2;
        n_chk++; if (frdy !== 2'b00) begin n_fail++; $display("FAIL fp_hold1: got %b want 00", frdy); end
        step();
        rd = 64'h0000_0000_DEAD_BEEF; fbrdata = rd;
        #2;
        n_chk++; if (frdy !== 2'b00) begin n_fail++; $display("FAIL fp_hold2: got %b want 00", frdy); end
        step();
        #2;
        n_chk++; if (frv !== 2'b01) begin n_fail++; $display("FAIL fp_pulse0: got %b want 01", frv); end
        n_chk++; if (frdata !== rd) begin n_fail++; $display("FAIL fp_rdata0: got %h want %h", frdata, rd); end
        n_chk++; if (frdy !== 2'b10) begin n_fail++; $display("FAIL fp_grant1: got %b want 10", frdy); end
        step();
        fv = 2'b00;
        #2;
        n_chk++; if (fbaddr !== 64'hAAAA_0001_0000_1000) begin n_fail++; $display("FAIL fp_addr1: got %h want aaaa000100001000", fbaddr); end
        step();
        fpend_rd = {$urandom, $urandom}; fbrdata = fpend_rd;
        step();
        fpend = 2'b10;
        for (int t = 0; t < 16; t++) begin
            fv = 2'($urandom_range(0, 3));
            faddr = {$urandom, $urandom, $urandom, $urandom};
            fbrdata = {$urandom, $urandom};
            #2;
            n_chk++; if (frv !== fpend) begin n_fail++; $display("FAIL fp_resp: got %b want %b", frv, fpend); end
            if (fpend != 0) begin
                n_chk++; if (frdata !== fpend_rd) begin n_fail++; $display("FAIL fp_rdata: got %h want %h", frdata, fpend_rd); end
                n_chk++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL fp_err: got %b want 0", ferr); end
            end
            exp = fv[0] ? 2'b01 : (fv[1] ? 2'b10 : 2'b00);
            n_chk++; if (frdy !== exp) begin n_fail++; $display("FAIL fp_grant: got %b want %b (valid %b)", frdy, exp, fv); end
            fa = exp[1] ? faddr[127:64] : faddr[63:0];
            fpend = 2'b00;
            step();
            if (exp == 2'b00) continue;
            fv = 2'($urandom_range(0, 3)); faddr = {$urandom, $urandom, $urandom, $urandom};
            #2;
            n_chk++; if (frdy !== 2'b00) begin n_fail++; $display("FAIL fp_issue_ready: got %b want 00", frdy); end
            n_chk++; if (fbaddr !== fa) begin n_fail++; $display("FAIL fp_issue_addr: got %h want %h", fbaddr, fa); end
            step();
            rd = {$urandom, $urandom}; fbrdata = rd;
            step();
            fpend = exp; fpend_rd = rd;
        end
        fv = 2'b00;
        #2;
        n_chk++; if (frv !== fpend) begin n_fail++; $display("FAIL fp_last_resp: got %b want %b", frv, fpend); end
        step();
        fbrdy = 1'b0; fbresp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read_latency();
        test_stall();
        test_timeout();
        test_fixed_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
